// File: rtl/branch_predictor_pkg.sv
// Shared types for the LC-3b branch predictor: opcodes, 2-bit counter states and the
// prediction tag carried down the pipeline barriers.
package branch_predictor_pkg;

   typedef enum logic [3:0] {
      op_br  = 4'b0000, op_add = 4'b0001, op_ldb = 4'b0010, op_stb = 4'b0011,
      op_jsr = 4'b0100, op_and = 4'b0101, op_ldw = 4'b0110, op_stw = 4'b0111,
      op_rti = 4'b1000, op_not = 4'b1001, op_ldi = 4'b1010, op_sti = 4'b1011,
      op_jmp = 4'b1100, op_shf = 4'b1101, op_lea = 4'b1110, op_trap = 4'b1111
   } lc3b_opcode;

   typedef enum logic [1:0] {SNT = 2'd0, WNT = 2'd1, WT = 2'd2, ST = 2'd3} lc3b_bp_counter;

   // Index field sized for the largest supported table (INDEX_BITS <= 8).
   typedef struct packed {
      logic       valid;
      logic       prediction;
      logic [7:0] index;
   } lc3b_bp_tag;

   localparam logic [15:0] BP_STAT_MAX = 16'hFFFF;

endpackage

// File: rtl/branch_predictor_pht.sv
// Pattern history table: 2-bit saturating counters, async read, one synchronous
// saturating update per cycle, async reset of every entry to weakly-not-taken.
module bp_pht
   import branch_predictor_pkg::*;
#(
   parameter int INDEX_BITS = 5
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [INDEX_BITS-1:0] rd_idx_i,
   output lc3b_bp_counter        rd_ctr_o,
   input  logic                  upd_en_i,
   input  logic [INDEX_BITS-1:0] upd_idx_i,
   input  logic                  upd_taken_i
);

   localparam int DEPTH = 1 << INDEX_BITS;

   lc3b_bp_counter ctr_q [DEPTH];
   lc3b_bp_counter upd_d;

   // Read returns the pre-edge value even when the same entry is being updated.
   assign rd_ctr_o = ctr_q[rd_idx_i];

   always_comb begin
      upd_d = ctr_q[upd_idx_i];
      if (upd_taken_i) begin
         if (ctr_q[upd_idx_i] != ST) upd_d = lc3b_bp_counter'(ctr_q[upd_idx_i] + 2'd1);
      end else begin
         if (ctr_q[upd_idx_i] != SNT) upd_d = lc3b_bp_counter'(ctr_q[upd_idx_i] - 2'd1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) ctr_q[i] <= WNT;
      end else if (upd_en_i) begin
         ctr_q[upd_idx_i] <= upd_d;
      end
   end

endmodule

// File: rtl/branch_predictor.sv
// Branch-direction predictor: PHT lookup at IF, tag chain to EX_MEM, training and
// statistics when a BR leaves MEM. Define BRANCH_PREDICTOR_GSHARE_EN for gshare indexing.
module branch_predictor
   import branch_predictor_pkg::*;
#(
   parameter int INDEX_BITS   = 5,
   parameter int HISTORY_BITS = 5
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [15:0] stage_IF_pc,
   input  logic        barrier_IF_ID_load,
   input  logic        barrier_ID_EX_load,
   input  logic        barrier_EX_MEM_load,
   input  logic        barrier_MEM_WB_load,
   input  logic        barrier_IF_ID_reset,
   input  logic        barrier_ID_EX_reset,
   input  logic        barrier_EX_MEM_reset,
   input  logic        barrier_EX_MEM_valid,
   input  lc3b_opcode  barrier_EX_MEM_opcode,
   input  logic        stage_MEM_br_en,
   output logic        stage_IF_prediction,
   output logic        branch_prediction,
   output logic [15:0] bp_branch_count,
   output logic [15:0] bp_mispredict_count
);

   logic [INDEX_BITS-1:0] if_idx;
   lc3b_bp_counter        if_ctr;
   lc3b_bp_tag            if_tag, if_id_q, id_ex_q, ex_mem_q;
   logic                  resolve;
   logic [15:0]           br_cnt_q, mis_cnt_q;

`ifdef BRANCH_PREDICTOR_GSHARE_EN
   logic [HISTORY_BITS-1:0] ghr_q;
   assign if_idx = stage_IF_pc[INDEX_BITS:1] ^ INDEX_BITS'(ghr_q);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)     ghr_q <= '0;
      else if (resolve) ghr_q <= {ghr_q[HISTORY_BITS-2:0], stage_MEM_br_en};
   end
`else
   assign if_idx = stage_IF_pc[INDEX_BITS:1];
`endif

   bp_pht #(.INDEX_BITS(INDEX_BITS)) u_pht (
      .clk         (clk),
      .reset_n     (reset_n),
      .rd_idx_i    (if_idx),
      .rd_ctr_o    (if_ctr),
      .upd_en_i    (resolve),
      .upd_idx_i   (ex_mem_q.index[INDEX_BITS-1:0]),
      .upd_taken_i (stage_MEM_br_en)
   );

   assign stage_IF_prediction = if_ctr[1];
   assign if_tag = '{valid: 1'b1, prediction: if_ctr[1], index: 8'(if_idx)};

   // Flush beats load at every barrier.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         if_id_q  <= '0;
         id_ex_q  <= '0;
         ex_mem_q <= '0;
      end else begin
         if (barrier_IF_ID_reset)       if_id_q  <= '0;
         else if (barrier_IF_ID_load)   if_id_q  <= if_tag;
         if (barrier_ID_EX_reset)       id_ex_q  <= '0;
         else if (barrier_ID_EX_load)   id_ex_q  <= if_id_q;
         if (barrier_EX_MEM_reset)      ex_mem_q <= '0;
         else if (barrier_EX_MEM_load)  ex_mem_q <= id_ex_q;
      end
   end

   assign branch_prediction = ex_mem_q.valid & ex_mem_q.prediction;

   // Fires only on the cycle the branch moves into WB, so a stalled BR trains once.
   assign resolve = barrier_MEM_WB_load & barrier_EX_MEM_valid &
                    (barrier_EX_MEM_opcode == op_br) & ex_mem_q.valid;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         br_cnt_q  <= '0;
         mis_cnt_q <= '0;
      end else if (resolve) begin
         if (br_cnt_q != BP_STAT_MAX) br_cnt_q <= br_cnt_q + 16'd1;
         if ((ex_mem_q.prediction != stage_MEM_br_en) && (mis_cnt_q != BP_STAT_MAX))
            mis_cnt_q <= mis_cnt_q + 16'd1;
      end
   end

   assign bp_branch_count     = br_cnt_q;
   assign bp_mispredict_count = mis_cnt_q;

   logic unused_bits;
   assign unused_bits = ^{stage_IF_pc[15:INDEX_BITS+1], stage_IF_pc[0], if_ctr[0],
                          ex_mem_q.index[7:INDEX_BITS], 1'(HISTORY_BITS)};

endmodule

// File: tb/tb_branch_predictor.sv
// Directed-vector bench for branch_predictor: tag chain, training, saturation,
// stalls, flushes, statistics and async reset.
module tb_branch_predictor;
   import branch_predictor_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [15:0] pc = 16'h0010;
   logic        if_ld = 0, id_ld = 0, ex_ld = 0, wb_ld = 0;
   logic        if_rst = 0, id_rst = 0, ex_rst = 0;
   logic        ex_valid = 1'b1;
   lc3b_opcode  op = op_add;
   logic        br_en = 1'b0;
   logic        ifp, bp;
   logic [15:0] bc, mc;
   int          ncmp = 0, nerr = 0;

   always #5 clk = ~clk;

   branch_predictor dut (
      .clk                   (clk),
      .reset_n               (reset_n),
      .stage_IF_pc           (pc),
      .barrier_IF_ID_load    (if_ld),
      .barrier_ID_EX_load    (id_ld),
      .barrier_EX_MEM_load   (ex_ld),
      .barrier_MEM_WB_load   (wb_ld),
      .barrier_IF_ID_reset   (if_rst),
      .barrier_ID_EX_reset   (id_rst),
      .barrier_EX_MEM_reset  (ex_rst),
      .barrier_EX_MEM_valid  (ex_valid),
      .barrier_EX_MEM_opcode (op),
      .stage_MEM_br_en       (br_en),
      .stage_IF_prediction   (ifp),
      .branch_prediction     (bp),
      .bp_branch_count       (bc),
      .bp_mispredict_count   (mc)
   );

   task automatic chk(input string nm, input logic [15:0] obs, input logic [15:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // All four barriers advance with a non-branch in EX_MEM.
   task automatic adv();
      op = op_add;
      {if_ld, id_ld, ex_ld, wb_ld} = 4'hF;
      tick();
      {if_ld, id_ld, ex_ld, wb_ld} = 4'h0;
   endtask

   // Retire the BR sitting in EX_MEM without moving the rest of the pipe.
   task automatic resolve(input logic taken);
      op = op_br; ex_valid = 1'b1; br_en = taken; wb_ld = 1'b1;
      tick();
      wb_ld = 1'b0; op = op_add;
   endtask

   initial begin
      #12 reset_n = 1'b1;
      tick();
      chk("rst_ifp", 16'(ifp), 16'h0);
      chk("rst_bp",  16'(bp),  16'h0);
      chk("rst_bc",  bc, 16'h0);
      chk("rst_mc",  mc, 16'h0);

      repeat (3) adv();
      chk("chain_bp", 16'(bp), 16'h0);
      chk("nonbr_bc", bc, 16'h0);
      chk("nonbr_mc", mc, 16'h0);

`ifndef BRANCH_PREDICTOR_GSHARE_EN
      resolve(1'b1);                         // ctr[8] 1->2, mispredicted
      chk("t1_ifp", 16'(ifp), 16'h1);
      chk("t1_bc",  bc, 16'd1);
      chk("t1_mc",  mc, 16'd1);
      repeat (3) adv();
      chk("t2_bp", 16'(bp), 16'h1);
      resolve(1'b1);                         // 2->3, correct
      chk("t2_bc", bc, 16'd2);
      chk("t2_mc", mc, 16'd1);
      chk("t2_ifp", 16'(ifp), 16'h1);

      resolve(1'b0); chk("nt1_ifp", 16'(ifp), 16'h1);   // 3->2
      resolve(1'b0); chk("nt2_ifp", 16'(ifp), 16'h0);   // 2->1
      resolve(1'b0); chk("nt3_ifp", 16'(ifp), 16'h0);   // 1->0
      resolve(1'b0); chk("nt4_ifp", 16'(ifp), 16'h0);   // stays 0
      chk("nt_bc", bc, 16'd6);
      chk("nt_mc", mc, 16'd5);
      resolve(1'b1); chk("sat0_ifp", 16'(ifp), 16'h0);  // 0->1
      resolve(1'b1); chk("inc_ifp",  16'(ifp), 16'h1);  // 1->2
      chk("inc_bc", bc, 16'd8);
      chk("inc_mc", mc, 16'd5);

      // Stalled BR at index 0x10.
      pc = 16'h0020;
      repeat (3) adv();
      chk("st_bp", 16'(bp), 16'h0);
      op = op_br; br_en = 1'b1; wb_ld = 1'b0;
      repeat (5) tick();
      chk("st_bc", bc, 16'd8);
      chk("st_mc", mc, 16'd5);
      wb_ld = 1'b1;
      #1 chk("rbw_ifp", 16'(ifp), 16'h0);
      tick();
      wb_ld = 1'b0; op = op_add;
      chk("st_bc1", bc, 16'd9);
      chk("st_mc1", mc, 16'd6);
      chk("st_ifp", 16'(ifp), 16'h1);

      // Flush a taken-predicted tag in ID_EX.
      adv(); adv();
      {id_rst, id_ld, ex_ld} = 3'b111;
      tick();
      {id_rst, id_ld, ex_ld} = 3'b000;
      chk("fl_bp_prev", 16'(bp), 16'h1);
      ex_ld = 1'b1; tick(); ex_ld = 1'b0;
      chk("fl_bp", 16'(bp), 16'h0);
      resolve(1'b1);
      chk("fl_bc", bc, 16'd9);
      chk("fl_mc", mc, 16'd6);

      // EX_MEM invalid bit suppresses training.
      repeat (3) adv();
      op = op_br; ex_valid = 1'b0; wb_ld = 1'b1; br_en = 1'b1;
      tick();
      wb_ld = 1'b0; ex_valid = 1'b1; op = op_add;
      chk("inv_bc", bc, 16'd9);

      // Flush in the resolve cycle still trains.
      ex_rst = 1'b1;
      resolve(1'b0);                         // ctr[16] 2->1, mispredicted
      ex_rst = 1'b0;
      chk("frs_bc", bc, 16'd10);
      chk("frs_mc", mc, 16'd7);
      chk("frs_bp", 16'(bp), 16'h0);
      chk("frs_ifp", 16'(ifp), 16'h0);

      // Async reset mid-cycle.
      pc = 16'h0010;
      #1 chk("pre_rst_ifp", 16'(ifp), 16'h1);
      #2 reset_n = 1'b0;
      #1;
      chk("arst_ifp", 16'(ifp), 16'h0);
      chk("arst_bc", bc, 16'h0);
      chk("arst_mc", mc, 16'h0);
      chk("arst_bp", 16'(bp), 16'h0);
`else
      resolve(1'b1);                         // ctr[8] 1->2, GHR=00001
      chk("g_ifp_09", 16'(ifp), 16'h0);      // pc 0x10 -> idx 0x09
      pc = 16'h0012;
      #1 chk("g_ifp_08", 16'(ifp), 16'h1);   // idx 0x09^1 = 0x08
      pc = 16'h0010;
      repeat (3) adv();
      chk("g_bp", 16'(bp), 16'h0);
      op = op_br; br_en = 1'b1; wb_ld = 1'b1;
      #1 chk("g_rbw", 16'(ifp), 16'h0);
      tick();
      wb_ld = 1'b0; op = op_add;             // ctr[9] 1->2, GHR=00011
      pc = 16'h0014;
      #1 chk("g_ifp_trained", 16'(ifp), 16'h1);
      chk("g_bc", bc, 16'd2);
      chk("g_mc", mc, 16'd2);
      #3 reset_n = 1'b0;
      #1 chk("g_arst_bc", bc, 16'h0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
